dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder for the Mem stage: one outstanding request,
// a configurable number of wait states, byte-enabled stores and error responses.
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        rsp_ready
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  // Storage is never reset so that contents survive rstn.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic              accept;
  logic              enter_resp;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_idx;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the accept edge itself, so the
  // live request is used instead of the (not yet loaded) latched copy.
  assign enter_resp = ((state == ST_IDLE) && req_valid && (WAIT == 0)) ||
                      ((state == ST_WAIT) && (cnt == 4'd1));
  assign acc_we    = (state == ST_IDLE) ? req_we    : we_q;
  assign acc_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state == ST_IDLE) ? req_be    : be_q;
  assign acc_err   = (|acc_addr[1:0]) || (|acc_addr[31:ADDR_W+2]);
  assign acc_idx   = acc_addr[ADDR_W+1:2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT == 0) state_nxt = ST_RESP;
          else           state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: if (cnt == 4'd1) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= WAIT_CNT;
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Write gated by rstn so an access racing a reset edge never lands.
  always_ff @(posedge clk) begin
    if (rstn && enter_resp && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a WAIT=2 responder for the main scenarios and a WAIT=0
// responder for back-to-back throughput.
module tb_dmem_responder;
  localparam int WAIT_A = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b1;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [3:0]  b_req_be = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.ADDR_W(10), .WAIT(WAIT_A)) dut_a (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready)
  );

  dmem_responder #(.ADDR_W(10), .WAIT(0)) dut_b (
    .clk(clk), .rstn(rstn),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .rsp_ready(b_rsp_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on dut_a: accept, wait for response, check, handshake.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rdata,
                      input logic exp_err, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(WAIT_A + 1));
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int rose;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_b_ready", 32'(b_req_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    // Basic store then load
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "st10");
    xact(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld10");

    // Partial byte-enable merge
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, "st20");
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, "st20p");
    xact(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, "ld20");

    // Zero byte enables and never-written word
    xact(1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, "stbe0");
    xact(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld10b");
    xact(1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, "ld30");

    // Error responses leave memory untouched
    xact(1'b1, 32'h0, 32'h01234567, 4'hF, 32'h0, 1'b0, "st0");
    xact(1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, "ldmis");
    xact(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, "ldoor");
    xact(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "stmis");
    xact(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "stoor");
    xact(1'b0, 32'h0, 32'h0, 4'h0, 32'h01234567, 1'b0, "ld0");

    // Backpressure in RESP while req_valid toggles
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_be = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (WAIT_A) @(posedge clk);
    #1;
    check("bp_valid0", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i % 2 == 0); req_we = 1'b1; req_addr = 32'h20;
      req_wdata = 32'h0; req_be = 4'hF;
      @(posedge clk); #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'h11BB33DD);
      check("bp_err", 32'(rsp_err), 32'd0);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_drop", 32'(rsp_valid), 32'd0);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_retain", rsp_rdata, 32'h11BB33DD);
    xact(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, "ld20b");

    // Reset during WAIT abandons the store
    xact(1'b1, 32'h40, 32'h55AA55AA, 4'hF, 32'h0, 1'b0, "st40");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rw_valid", 32'(rsp_valid), 32'd0);
    check("rw_ready", 32'(req_ready), 32'd1);
    check("rw_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    rose = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) rose = 1;
    end
    check("rw_norsp", 32'(rose), 32'd0);
    xact(1'b0, 32'h40, 32'h0, 4'h0, 32'h55AA55AA, 1'b0, "ld40");

    // Zero-wait-state responder, back-to-back with rsp_ready tied high
    @(negedge clk);
    check("b_ready0", 32'(b_req_ready), 32'd1);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h8;
    b_req_wdata = 32'h0BADCAFE; b_req_be = 4'hF;
    @(posedge clk); #1;
    check("b_st_valid", 32'(b_rsp_valid), 32'd1);
    check("b_st_rdata", b_rsp_rdata, 32'd0);
    check("b_st_err", 32'(b_rsp_err), 32'd0);
    check("b_st_ready", 32'(b_req_ready), 32'd0);
    b_req_we = 1'b0; b_req_be = 4'h0; b_req_wdata = '0;
    @(posedge clk); #1;
    check("b_gap1_valid", 32'(b_rsp_valid), 32'd0);
    check("b_gap1_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    check("b_ld_valid", 32'(b_rsp_valid), 32'd1);
    check("b_ld_rdata", b_rsp_rdata, 32'h0BADCAFE);
    check("b_ld_err", 32'(b_rsp_err), 32'd0);
    b_req_addr = 32'h9;
    @(posedge clk); #1;
    check("b_gap2_valid", 32'(b_rsp_valid), 32'd0);
    check("b_gap2_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    check("b_mis_valid", 32'(b_rsp_valid), 32'd1);
    check("b_mis_err", 32'(b_rsp_err), 32'd1);
    check("b_mis_rdata", b_rsp_rdata, 32'd0);
    b_req_valid = 1'b0;
    @(posedge clk); #1;
    check("b_end_valid", 32'(b_rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("b_end_idle", 32'(b_rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
